// File: rtl/coin_score_keeper.sv
// rtl/coin_score_keeper.sv - turns first coin touches into SKY tile writes, tracks collected mask and BCD score
module coin_score_keeper #(
    parameter int                     NUM_COINS  = 2,
    parameter logic [7:0]             SKY        = 8'd1,
    parameter logic [4*NUM_COINS-1:0] COIN_ROWS  = {4'd6, 4'd1},
    parameter logic [5*NUM_COINS-1:0] COIN_COLS  = {5'd6, 5'd15},
    parameter logic [3:0]             COIN_VALUE = 4'd1
) (
    input  logic                 vga_clock,
    input  logic                 reset,
    input  logic [NUM_COINS-1:0] touch,
    input  logic                 tile_wr_ready,
    output logic                 tile_wr_valid,
    output logic [3:0]           tile_wr_row,
    output logic [4:0]           tile_wr_col,
    output logic [7:0]           tile_wr_data,
    output logic [NUM_COINS-1:0] collected,
    output logic                 coin_event,
    output logic [11:0]          score_bcd,
    output logic                 all_collected
);

    localparam int IW = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, SCORE} state_t;

    state_t               state, state_next;
    logic [NUM_COINS-1:0] touch_q, pending, rise, sel_mask;
    logic [IW-1:0]        sel, low_idx;
    logic                 load, fire;
    logic [11:0]          score_q;

    // Decimal add that pins at 999 instead of wrapping.
    function automatic logic [11:0] bcd_add(input logic [11:0] s, input logic [3:0] v);
        logic [4:0] d0, d1, d2;
        d0 = {1'b0, s[3:0]} + {1'b0, v};
        d1 = {1'b0, s[7:4]};
        d2 = {1'b0, s[11:8]};
        if (d0 > 5'd9) begin
            d0 = d0 - 5'd10;
            d1 = d1 + 5'd1;
        end
        if (d1 > 5'd9) begin
            d1 = d1 - 5'd10;
            d2 = d2 + 5'd1;
        end
        if (d2 > 5'd9) return 12'h999;
        return {d2[3:0], d1[3:0], d0[3:0]};
    endfunction

    always_comb begin
        rise    = touch & ~touch_q & ~collected & ~pending;
        low_idx = '0;
        for (int i = NUM_COINS - 1; i >= 0; i--) begin
            if (pending[i]) low_idx = IW'(i);
        end
        sel_mask      = '0;
        sel_mask[sel] = 1'b1;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (|pending) begin
                    load       = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (tile_wr_ready) begin
                    fire       = 1'b1;
                    state_next = SCORE;
                end
            end
            SCORE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            state         <= IDLE;
            touch_q       <= '0;
            pending       <= '0;
            collected     <= '0;
            sel           <= '0;
            tile_wr_valid <= 1'b0;
            tile_wr_row   <= '0;
            tile_wr_col   <= '0;
            coin_event    <= 1'b0;
            score_q       <= '0;
        end else begin
            state         <= state_next;
            touch_q       <= touch;
            // Rises landing while a write is in flight are merged here, never dropped.
            pending       <= (pending | rise) & ~({NUM_COINS{fire}} & sel_mask);
            if (fire) collected <= collected | sel_mask;
            if (load) begin
                sel         <= low_idx;
                tile_wr_row <= COIN_ROWS[int'(low_idx)*4 +: 4];
                tile_wr_col <= COIN_COLS[int'(low_idx)*5 +: 5];
            end
            tile_wr_valid <= (state_next == ISSUE);
            coin_event    <= (state == SCORE);
            if (state == SCORE) score_q <= bcd_add(score_q, COIN_VALUE);
        end
    end

    assign tile_wr_data  = SKY;
    assign score_bcd     = score_q;
    assign all_collected = &collected;

endmodule

// File: tb/tb_coin_score_keeper.sv
// tb/tb_coin_score_keeper.sv - scoreboard bench for coin_score_keeper
module tb_coin_score_keeper;

    logic        vga_clock = 1'b0;
    logic        reset;
    logic [1:0]  touch;
    logic        tile_wr_ready;
    logic        tile_wr_valid;
    logic [3:0]  tile_wr_row;
    logic [4:0]  tile_wr_col;
    logic [7:0]  tile_wr_data;
    logic [1:0]  collected;
    logic        coin_event;
    logic [11:0] score_bcd;
    logic        all_collected;

    // coin0 at row 6 / col 6, coin1 at row 1 / col 15 (coin0 in LSBs)
    coin_score_keeper #(
        .NUM_COINS (2),
        .SKY       (8'd1),
        .COIN_ROWS ({4'd1, 4'd6}),
        .COIN_COLS ({5'd15, 5'd6}),
        .COIN_VALUE(4'd1)
    ) dut (
        .vga_clock    (vga_clock),
        .reset        (reset),
        .touch        (touch),
        .tile_wr_ready(tile_wr_ready),
        .tile_wr_valid(tile_wr_valid),
        .tile_wr_row  (tile_wr_row),
        .tile_wr_col  (tile_wr_col),
        .tile_wr_data (tile_wr_data),
        .collected    (collected),
        .coin_event   (coin_event),
        .score_bcd    (score_bcd),
        .all_collected(all_collected)
    );

    always #5 vga_clock = ~vga_clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wr_count = 0, ev_count = 0, valid_cnt = 0;
    int last_hs = 0, hs_gap = 0;
    logic [31:0] exp_wr[$];
    logic [31:0] exp_ev[$];

    localparam logic [31:0] WR_C0 = {15'd0, 4'd6, 5'd6, 8'd1};
    localparam logic [31:0] WR_C1 = {15'd0, 4'd1, 5'd15, 8'd1};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge vga_clock);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        int k;
        k = 0;
        while (!tile_wr_valid && k < 20) begin
            @(negedge vga_clock);
            k++;
        end
        chk(nm, {31'd0, tile_wr_valid}, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        touch = 2'b00;
        tick(2);
        reset = 1'b0;
    endtask

    // Monitor: pops expected writes and score values whenever the DUT presents them.
    always @(negedge vga_clock) begin
        cyc++;
        if (!reset) begin
            if (tile_wr_valid) valid_cnt++;
            if (tile_wr_valid && tile_wr_ready) begin
                wr_count++;
                hs_gap  = cyc - last_hs;
                last_hs = cyc;
                if (exp_wr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got row=%0d col=%0d", tile_wr_row, tile_wr_col);
                end else begin
                    chk("tile_write", {15'd0, tile_wr_row, tile_wr_col, tile_wr_data}, exp_wr.pop_front());
                end
            end
            if (coin_event) begin
                ev_count++;
                if (exp_ev.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_coin_event: got score=%h", score_bcd);
                end else begin
                    chk("score_at_event", {20'd0, score_bcd}, exp_ev.pop_front());
                end
            end
        end
    end

    logic [1:0] exp_valid [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0] exp_event [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int w0, e0, v0;
        logic stable;

        tile_wr_ready = 1'b1;
        reset = 1'b1;
        touch = 2'b00;
        tick(2);
        @(negedge vga_clock);
        chk("rst_valid", {31'd0, tile_wr_valid}, 32'd0);
        chk("rst_rowcol", {23'd0, tile_wr_row, tile_wr_col}, 32'd0);
        chk("rst_data", {24'd0, tile_wr_data}, 32'd1);
        chk("rst_collected", {30'd0, collected}, 32'd0);
        chk("rst_event", {31'd0, coin_event}, 32'd0);
        chk("rst_score", {20'd0, score_bcd}, 32'd0);
        chk("rst_all", {31'd0, all_collected}, 32'd0);
        tick(1);
        reset = 1'b0;

        // Idle: no touches, nothing happens
        v0 = valid_cnt;
        tick(10);
        chk("idle_no_valid", valid_cnt - v0, 32'd0);
        chk("idle_score", {20'd0, score_bcd}, 32'd0);

        // Single coin with latency profile, held 100 cycles then pulsed again
        exp_wr.push_back(WR_C0);
        exp_ev.push_back(32'h001);
        w0 = wr_count;
        touch = 2'b01;
        for (int k = 0; k < 5; k++) begin
            @(negedge vga_clock);
            chk($sformatf("lat_valid_%0d", k), {31'd0, tile_wr_valid}, {31'd0, exp_valid[k][0]});
            chk($sformatf("lat_event_%0d", k), {31'd0, coin_event}, {31'd0, exp_event[k][0]});
        end
        chk("single_collected", {30'd0, collected}, 32'h1);
        chk("single_score", {20'd0, score_bcd}, 32'h001);
        tick(100);
        touch = 2'b00;
        tick(3);
        touch = 2'b01;
        tick(10);
        touch = 2'b00;
        chk("held_one_write", wr_count - w0, 32'd1);
        chk("held_score", {20'd0, score_bcd}, 32'h001);

        // Simultaneous rises: ascending order, 3 cycles apart
        do_reset();
        exp_wr.push_back(WR_C0);
        exp_wr.push_back(WR_C1);
        exp_ev.push_back(32'h001);
        exp_ev.push_back(32'h002);
        touch = 2'b11;
        tick(15);
        chk("pair_gap", hs_gap, 32'd3);
        chk("pair_score", {20'd0, score_bcd}, 32'h002);
        chk("pair_collected", {30'd0, collected}, 32'h3);
        chk("pair_all", {31'd0, all_collected}, 32'd1);

        // Back-pressure: ready low 20 cycles, outputs must hold
        do_reset();
        tile_wr_ready = 1'b0;
        exp_wr.push_back(WR_C1);
        exp_ev.push_back(32'h001);
        w0 = wr_count;
        touch = 2'b10;
        wait_valid("stall_valid_seen");
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge vga_clock);
            if (!(tile_wr_valid && tile_wr_row == 4'd1 && tile_wr_col == 5'd15 && tile_wr_data == 8'd1))
                stable = 1'b0;
        end
        chk("stall_stable", {31'd0, stable}, 32'd1);
        tick(1);
        tile_wr_ready = 1'b1;
        tick(6);
        chk("stall_one_write", wr_count - w0, 32'd1);
        chk("stall_score", {20'd0, score_bcd}, 32'h001);
        chk("stall_collected", {30'd0, collected}, 32'h2);

        // Saturation: preload 998, then three coins total
        do_reset();
        e0 = ev_count;
        force dut.score_q = 12'h998;
        tick(1);
        release dut.score_q;
        exp_wr.push_back(WR_C0);
        exp_wr.push_back(WR_C1);
        exp_ev.push_back(32'h999);
        exp_ev.push_back(32'h999);
        touch = 2'b11;
        tick(15);
        do_reset();
        force dut.score_q = 12'h999;
        tick(1);
        release dut.score_q;
        exp_wr.push_back(WR_C0);
        exp_ev.push_back(32'h999);
        touch = 2'b01;
        tick(10);
        touch = 2'b00;
        chk("sat_events", ev_count - e0, 32'd3);
        chk("sat_score", {20'd0, score_bcd}, 32'h999);

        // Reset while a write is pending
        do_reset();
        tile_wr_ready = 1'b0;
        touch = 2'b11;
        wait_valid("abort_valid_seen");
        tick(1);
        reset = 1'b1;
        touch = 2'b00;
        tick(1);
        @(negedge vga_clock);
        chk("abort_valid", {31'd0, tile_wr_valid}, 32'd0);
        chk("abort_collected", {30'd0, collected}, 32'd0);
        chk("abort_score", {20'd0, score_bcd}, 32'd0);
        tick(1);
        reset = 1'b0;
        tile_wr_ready = 1'b1;
        w0 = wr_count;
        v0 = valid_cnt;
        tick(10);
        chk("abort_no_write", wr_count - w0, 32'd0);
        chk("abort_no_valid", valid_cnt - v0, 32'd0);

        chk("wr_queue_empty", exp_wr.size(), 32'd0);
        chk("ev_queue_empty", exp_ev.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
